// File: rtl/dist_window_avg.sv
// Sliding-window moving average of a distance stream with a hysteretic proximity alarm.
// Optional peak-distance tracking is compiled in with the DIST_PEAK_HOLD_EN macro.
module dist_window_avg #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [7:0]  ALARM_HI   = 8'd200,
  parameter logic [7:0]  ALARM_LO   = 8'd180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       clear,
  output logic [7:0] avg_out,
  output logic       avg_valid,
  output logic       alarm,
  output logic [7:0] peak_out
);

  localparam int N  = 1 << DEPTH_LOG2;
  localparam int SW = 8 + DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;

  // Handshake: din is consumed on every rising edge where din_valid is high
  // and clear is low; there is no back-pressure, so a sample can be taken every cycle.

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_buf [N];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [CW-1:0]         r_fill_cnt;
  logic [CW-1:0]         w_fill_next;
  logic [SW-1:0]         r_sum;
  logic [SW-1:0]         w_sum_next;
  logic [7:0]            r_avg;
  logic                  r_avg_valid;
  logic                  r_alarm;
  logic                  w_accept;
  logic                  w_avg_upd;
  logic [7:0]            w_avg_new;
  logic                  w_alarm_new;

  assign w_accept   = din_valid & ~clear;
  // Evicted slot is always 0 during FILL because reset/clear zero the whole buffer.
  assign w_sum_next = r_sum + SW'(din) - SW'(r_buf[r_wr_ptr]);
  assign w_avg_new  = w_sum_next[SW-1:DEPTH_LOG2];

  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill_cnt;
    w_avg_upd    = 1'b0;
    if (clear) begin
      w_state_next = S_FILL;
      w_fill_next  = '0;
    end else if (w_accept) begin
      case (r_state)
        S_FILL: begin
          w_fill_next = r_fill_cnt + CW'(1);
          if (w_fill_next == CW'(N)) begin
            w_state_next = S_RUN;
            w_avg_upd    = 1'b1;
          end
        end
        S_RUN: begin
          w_avg_upd = 1'b1;
        end
        default: begin
          w_state_next = S_FILL;
        end
      endcase
    end
  end

  always_comb begin
    w_alarm_new = r_alarm;
    if (w_avg_new >= ALARM_HI) begin
      w_alarm_new = 1'b1;
    end else if (w_avg_new <= ALARM_LO) begin
      w_alarm_new = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_sum       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fill_cnt <= w_fill_next;
      if (clear) begin
        r_wr_ptr    <= '0;
        r_sum       <= '0;
        r_avg       <= '0;
        r_avg_valid <= 1'b0;
        r_alarm     <= 1'b0;
      end else if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
        r_sum    <= w_sum_next;
        if (w_avg_upd) begin
          r_avg       <= w_avg_new;
          r_avg_valid <= 1'b1;
          r_alarm     <= w_alarm_new;
        end
      end
    end
  end

  assign avg_out   = r_avg;
  assign avg_valid = r_avg_valid;
  assign alarm     = r_alarm;

`ifdef DIST_PEAK_HOLD_EN
  logic [7:0] r_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (clear) begin
      r_peak <= '0;
    end else if (w_accept && (din > r_peak)) begin
      r_peak <= din;
    end
  end

  assign peak_out = r_peak;
`else
  assign peak_out = 8'd0;
`endif

endmodule

// File: doc/dist_window_avg.md
Name: dist_window_avg

Overview:
- Downstream consumer of the Pythagorean distance stage; takes its 8-bit distance result as a sample stream.
- Keeps a sliding window of the last 2^DEPTH_LOG2 accepted samples in a circular buffer and outputs the registered moving average.
- Raises a hysteretic proximity alarm from that average.
- Optionally tracks the peak distance since the last clear.

Parameters:
- DEPTH_LOG2, 3, log2 of window length; window N = 2^DEPTH_LOG2 (legal range 1..6).
- ALARM_HI, 8'd200, average at or above this sets the alarm.
- ALARM_LO, 8'd180, average at or below this clears the alarm; ALARM_LO < ALARM_HI is required.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  8  distance sample (upstream sqrt_out).
- din_valid  input  1  sample accepted on any rising edge where high.
- clear  input  1  synchronous flush of window, alarm and peak.
- avg_out  output  8  moving average of last N samples.
- avg_valid  output  1  high once the window holds N samples.
- alarm  output  1  hysteretic threshold flag.
- peak_out  output  8  peak sample since clear (see Optional Feature).

Behaviour:
- One clock, asynchronous active-low reset.
- Reset state (async, immediate):
  - FSM = FILL; buffer entries, wr_ptr, fill_cnt and running sum all 0.
  - avg_out = 0, avg_valid = 0, alarm = 0, peak_out = 0.
- Storage:
  - N x 8-bit circular buffer; wr_ptr is DEPTH_LOG2 bits and wraps N-1 -> 0 naturally.
  - Running sum is 8+DEPTH_LOG2 bits; it can never overflow.
- Sample accept (din_valid=1, clear=0):
  - sum_next = sum + din - buf[wr_ptr]; buf[wr_ptr] <= din; wr_ptr++.
  - In FILL the evicted entry is 0 because of reset/clear, so sum_next = sum + din.
- No-accept cycle (din_valid=0): all state holds and outputs are unchanged.
- FSM:
  - FILL: fill_cnt increments per accept. When the accept brings fill_cnt to N, go to RUN in the same edge.
  - RUN: every accept updates the average; fill_cnt saturates at N.
  - Any state, clear=1: go to FILL, zero buffer, pointer, count, sum, avg_out, avg_valid, alarm and peak. clear has priority over a simultaneous din_valid; that sample is dropped.
- Average:
  - avg_out <= sum_next >> DEPTH_LOG2 (truncating), registered on each accept in RUN and on the FILL->RUN accept.
  - Latency: visible the cycle after the accepting edge.
  - avg_valid <= 1 on the FILL->RUN edge and stays 1 until clear or reset.
  - During FILL, avg_out holds 0.
- Alarm:
  - Evaluated only when avg_out is being updated, using the new average value.
  - new avg >= ALARM_HI sets alarm to 1.
  - new avg <= ALARM_LO clears alarm to 0.
  - Between the thresholds, alarm holds.
  - Alarm is always 0 while avg_valid = 0.
- Back-to-back din_valid every cycle is supported at full throughput with no stall.
- Reset asserted mid-stream returns immediately to the reset state; no partial window survives.

Optional Feature:
- Macro: DIST_PEAK_HOLD_EN.
- Defined: peak_out <= max(peak_out, din) on every accepted sample, FILL or RUN. Registered, visible next cycle. Zeroed by clear and reset.
- Not defined: peak_out is tied to 8'd0 and no peak register is synthesized.

Test Plan:
- Fill (N=8): reset, then 8 accepts of din=10. Required: avg_valid rises the cycle after the 8th accept, avg_out=10, alarm=0.
- Slide and truncate: continue with din=17 x 3. Required: sums 87, 94, 101 give avg_out 10, 11, 12.
- Hysteresis: run at steady din=210 until avg_out=210, so alarm=1. Then steady din=190 until avg_out=190: alarm stays 1. Then din=170 until the first avg <=180: alarm drops to 0. Going back to avg 190: alarm stays 0.
- Clear priority: in RUN with alarm=1, assert clear and din_valid=1 with din=255 together. Next cycle: avg_valid=0, avg_out=0, alarm=0. A full refill with din=4 yields avg_out=4, showing no residue from the dropped sample.
- Async reset mid-fill: after 5 accepts, pulse rst_n low between edges. Required: outputs go to 0 immediately, and 8 new accepts are needed before avg_valid=1.
- With DIST_PEAK_HOLD_EN: samples 30, 250, 40. Required: peak_out = 30, then 250, then 250. After clear: 0. Without the macro: peak_out is 0 throughout.
